// File: rtl/hls_accel_ctrl_pkg.sv
// ============================================================================
// Module   : hls_accel_ctrl_pkg
// Brief    : Shared FSM encodings, register offsets and bit indices for the
//            HLS core sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hls_accel_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESET = 2'd3;

    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_STATUS  = 5'h04;
    localparam logic [4:0] REG_ARG     = 5'h08;
    localparam logic [4:0] REG_RET     = 5'h0C;
    localparam logic [4:0] REG_TIMEOUT = 5'h10;
    localparam logic [4:0] REG_CYCLES  = 5'h14;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_CLEAR   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_IDLE    = 3;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hls_accel_ctrl_regs.sv
// ============================================================================
// Module   : hls_accel_ctrl_regs
// Brief    : Bus decode, ARG/TIMEOUT storage, CTRL strobes and registered
//            one-cycle read response for the HLS core sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hls_accel_ctrl_regs
    import hls_accel_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_bus_req,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [3:0]  i_bus_be,
    input  logic [31:0] i_bus_wdata,
    output logic        o_bus_ack,
    output logic        o_bus_resp,
    output logic [31:0] o_bus_rdata,
    input  logic        i_busy,
    input  logic [3:0]  i_status,
    input  logic [31:0] i_ret,
    input  logic [31:0] i_cycles,
    output logic [31:0] o_arg,
    output logic [31:0] o_timeout,
    output logic        o_start,
    output logic        o_abort,
    output logic        o_clear
);

    logic [31:0] w_off;
    logic [4:0]  w_reg;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic [31:0] w_rdata;
    logic [31:0] r_arg;
    logic [31:0] r_timeout;
    logic        r_resp;
    logic [31:0] r_rdata;

    // Subtracting the base keeps the decode valid for any BASE_ADDR alignment;
    // unaligned offsets inside the window match no register.
    assign w_off     = i_bus_addr - BASE_ADDR;
    assign w_reg     = w_off[4:0];
    assign w_hit     = i_bus_req && (w_off < 32'd32);
    assign w_wr      = w_hit && i_bus_we;
    assign w_rd      = w_hit && !i_bus_we;
    assign w_ctrl_wr = w_wr && (w_reg == REG_CTRL) && i_bus_be[0];

    assign o_bus_ack   = w_hit;
    assign o_bus_resp  = r_resp;
    assign o_bus_rdata = r_rdata;
    assign o_arg       = r_arg;
    assign o_timeout   = r_timeout;
    assign o_start     = w_ctrl_wr && i_bus_wdata[CTRL_START];
    assign o_abort     = w_ctrl_wr && i_bus_wdata[CTRL_ABORT];
    assign o_clear     = w_ctrl_wr && i_bus_wdata[CTRL_CLEAR];

    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            REG_STATUS:  w_rdata = {28'd0, i_status};
            REG_ARG:     w_rdata = r_arg;
            REG_RET:     w_rdata = i_ret;
            REG_TIMEOUT: w_rdata = r_timeout;
            REG_CYCLES:  w_rdata = i_cycles;
            default:     w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_resp    <= 1'b0;
            r_rdata   <= 32'd0;
            r_arg     <= 32'd0;
            r_timeout <= TIMEOUT_DEFAULT;
        end else begin
            r_resp  <= w_rd;
            r_rdata <= w_rd ? w_rdata : 32'd0;
            if (w_wr && (w_reg == REG_ARG) && !i_busy)
                r_arg <= be_merge(r_arg, i_bus_wdata, i_bus_be);
            if (w_wr && (w_reg == REG_TIMEOUT))
                r_timeout <= be_merge(r_timeout, i_bus_wdata, i_bus_be);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hls_accel_ctrl.sv
// ============================================================================
// Module   : hls_accel_ctrl
// Brief    : CSR-mapped ap_ctrl_hs sequencer with latched result, sticky
//            status and watchdog reset. HLS_ACCEL_CTRL_CYCLES_EN adds a
//            run-length cycle counter at offset 0x14.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hls_accel_ctrl
    import hls_accel_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
    parameter int          RST_CYCLES      = 4,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd0
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        ap_start_o,
    input  logic        ap_ready_i,
    input  logic        ap_done_i,
    input  logic        ap_idle_i,
    input  logic [31:0] ap_return_bi,
    output logic [31:0] arg_bo,
    output logic        accel_rst_o,
    output logic        busy_o,
    output logic        irq_o
);

    logic [1:0]  r_state;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_ret;
    logic [31:0] r_wd;
    logic [31:0] r_rst_cnt;
    logic [31:0] w_timeout;
    logic [31:0] w_cycles;
    logic [3:0]  w_status;
    logic        w_start;
    logic        w_abort;
    logic        w_clear;
    logic        w_running;
    logic        w_wd_hit;
    logic        w_finish;

    hls_accel_ctrl_regs #(
        .BASE_ADDR       (BASE_ADDR),
        .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
    ) u_regs (
        .i_clk       (clk_i),
        .i_arst_n    (arst_n_i),
        .i_bus_req   (bus_req_i),
        .i_bus_we    (bus_we_i),
        .i_bus_addr  (bus_addr_bi),
        .i_bus_be    (bus_be_bi),
        .i_bus_wdata (bus_wdata_bi),
        .o_bus_ack   (bus_ack_o),
        .o_bus_resp  (bus_resp_o),
        .o_bus_rdata (bus_rdata_bo),
        .i_busy      (busy_o),
        .i_status    (w_status),
        .i_ret       (r_ret),
        .i_cycles    (w_cycles),
        .o_arg       (arg_bo),
        .o_timeout   (w_timeout),
        .o_start     (w_start),
        .o_abort     (w_abort),
        .o_clear     (w_clear)
    );

    assign w_running = (r_state == S_START) || (r_state == S_WAIT);
    assign w_wd_hit  = (w_timeout != 32'd0) && (r_wd == w_timeout - 32'd1);
    assign w_finish  = ((r_state == S_START) && ap_ready_i && ap_done_i) ||
                       ((r_state == S_WAIT) && ap_done_i);

    assign ap_start_o  = (r_state == S_START);
    assign accel_rst_o = (r_state == S_RESET);
    assign busy_o      = (r_state != S_IDLE);
    assign irq_o       = r_done || r_timeout;

    always_comb begin
        w_status               = 4'd0;
        w_status[STAT_BUSY]    = busy_o;
        w_status[STAT_DONE]    = r_done;
        w_status[STAT_TIMEOUT] = r_timeout;
        w_status[STAT_IDLE]    = ap_idle_i;
    end

    // Priority inside a run: abort, then watchdog, then completion.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ret     <= 32'd0;
            r_wd      <= 32'd0;
            r_rst_cnt <= 32'd0;
        end else begin
            if (w_clear) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_wd      <= 32'd0;
                        r_state   <= S_START;
                    end
                end
                S_START, S_WAIT: begin
                    if (w_abort) begin
                        r_rst_cnt <= 32'(RST_CYCLES - 1);
                        r_state   <= S_RESET;
                    end else if (w_wd_hit) begin
                        r_timeout <= 1'b1;
                        r_rst_cnt <= 32'(RST_CYCLES - 1);
                        r_state   <= S_RESET;
                    end else if (w_finish) begin
                        r_ret   <= ap_return_bi;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        if (w_timeout != 32'd0) r_wd <= r_wd + 32'd1;
                        if ((r_state == S_START) && ap_ready_i) r_state <= S_WAIT;
                    end
                end
                S_RESET: begin
                    if (r_rst_cnt == 32'd0) r_state   <= S_IDLE;
                    else                    r_rst_cnt <= r_rst_cnt - 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HLS_ACCEL_CTRL_CYCLES_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cycles <= 32'd0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_cycles <= 32'd0;
        end else if (w_running && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hls_accel_ctrl.sv
// ============================================================================
// Module   : tb_hls_accel_ctrl
// Brief    : Self-checking bench for hls_accel_ctrl; read data is checked
//            against a queue of expected values pushed at request time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hls_accel_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        bus_req_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic [31:0] bus_addr_bi = 32'd0;
    logic [3:0]  bus_be_bi = 4'd0;
    logic [31:0] bus_wdata_bi = 32'd0;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic        ap_start_o;
    logic        ap_ready_i = 1'b0;
    logic        ap_done_i = 1'b0;
    logic        ap_idle_i = 1'b1;
    logic [31:0] ap_return_bi = 32'd0;
    logic [31:0] arg_bo;
    logic        accel_rst_o;
    logic        busy_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    hls_accel_ctrl #(
        .BASE_ADDR       (BASE),
        .RST_CYCLES      (4),
        .TIMEOUT_DEFAULT (32'd0)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_addr_bi  (bus_addr_bi),
        .bus_be_bi    (bus_be_bi),
        .bus_wdata_bi (bus_wdata_bi),
        .bus_ack_o    (bus_ack_o),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .ap_start_o   (ap_start_o),
        .ap_ready_i   (ap_ready_i),
        .ap_done_i    (ap_done_i),
        .ap_idle_i    (ap_idle_i),
        .ap_return_bi (ap_return_bi),
        .arg_bo       (arg_bo),
        .accel_rst_o  (accel_rst_o),
        .busy_o       (busy_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        @(posedge clk_i); #1;
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = BASE + off;
        bus_be_bi = 4'hF; bus_wdata_bi = data;
        @(posedge clk_i); #1;
        bus_req_i = 1'b0; bus_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, input logic [31:0] exp, input string nm);
        logic [31:0] e;
        @(posedge clk_i); #1;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + off; bus_be_bi = 4'hF;
        exp_q.push_back(exp);
        @(negedge clk_i);
        checks++;
        if (bus_ack_o !== 1'b1) begin
            errors++; $display("FAIL %s_ack: got %b want 1", nm, bus_ack_o);
        end
        @(posedge clk_i); #1;
        bus_req_i = 1'b0;
        @(negedge clk_i);
        e = exp_q.pop_front();
        checks++;
        if (bus_resp_o !== 1'b1 || bus_rdata_bo !== e) begin
            errors++;
            $display("FAIL %s: resp=%b data=%h want resp=1 data=%h", nm, bus_resp_o, bus_rdata_bo, e);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 50) begin
            @(posedge clk_i); #1; n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL %s_idle: busy=%b after %0d cycles want 0", nm, busy_o, n);
        end
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        #23;
        checks++;
        if ({bus_ack_o, bus_resp_o, ap_start_o, accel_rst_o, busy_o, irq_o} !== 6'd0 || arg_bo !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: got ack/resp/start/rst/busy/irq=%b arg=%h want 0",
                {bus_ack_o, bus_resp_o, ap_start_o, accel_rst_o, busy_o, irq_o}, arg_bo);
        end
        @(posedge clk_i); #1;
        arst_n_i = 1'b1;
        bus_read(32'h04, 32'h8, "reset_status");
        bus_read(32'h08, 32'h0, "reset_arg");
        bus_read(32'h0C, 32'h0, "reset_ret");
        bus_read(32'h10, 32'h0, "reset_timeout");
    endtask

    task automatic test_normal_run();
        int starts;
        bus_write(32'h08, 32'h10);
        ap_idle_i = 1'b0;
        bus_write(32'h00, 32'h1);
        starts = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) ap_ready_i = 1'b1;
            @(negedge clk_i);
            if (ap_start_o === 1'b1) starts++;
            @(posedge clk_i); #1;
            ap_ready_i = 1'b0;
        end
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin ap_done_i = 1'b1; ap_return_bi = 32'hDEADBEEF; end
            @(negedge clk_i);
            if (ap_start_o === 1'b1) starts++;
            @(posedge clk_i); #1;
            ap_done_i = 1'b0; ap_return_bi = 32'd0;
        end
        ap_idle_i = 1'b1;
        @(negedge clk_i);
        if (ap_start_o === 1'b1) starts++;
        checks++;
        if (starts != 4) begin
            errors++; $display("FAIL run_start_len: got %0d cycles want 4", starts);
        end
        checks++;
        if (arg_bo !== 32'h10 || irq_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL run_outputs: arg=%h irq=%b busy=%b want 10/1/0", arg_bo, irq_o, busy_o);
        end
        bus_read(32'h0C, 32'hDEADBEEF, "run_ret");
        bus_read(32'h04, 32'hA, "run_status");
`ifdef HLS_ACCEL_CTRL_CYCLES_EN
        bus_read(32'h14, 32'd9, "run_cycles");
        repeat (5) @(posedge clk_i);
        bus_read(32'h14, 32'd9, "run_cycles_hold");
`else
        bus_read(32'h14, 32'd0, "run_cycles_off");
`endif
        bus_write(32'h00, 32'h4);
        bus_read(32'h04, 32'h8, "clear_status");
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++; $display("FAIL clear_irq: got %b want 0", irq_o);
        end
    endtask

    task automatic test_single_cycle();
        logic [31:0] e;
        ap_idle_i = 1'b0;
        bus_write(32'h00, 32'h1);
        ap_ready_i = 1'b1; ap_done_i = 1'b1; ap_return_bi = 32'h5;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'h04;
        exp_q.push_back(32'h1);
        @(negedge clk_i);
        checks++;
        if (ap_start_o !== 1'b1) begin
            errors++; $display("FAIL single_start_hi: got %b want 1", ap_start_o);
        end
        @(posedge clk_i); #1;
        ap_ready_i = 1'b0; ap_done_i = 1'b0; ap_return_bi = 32'd0; bus_req_i = 1'b0;
        ap_idle_i = 1'b1;
        @(negedge clk_i);
        e = exp_q.pop_front();
        checks++;
        if (bus_resp_o !== 1'b1 || bus_rdata_bo !== e) begin
            errors++; $display("FAIL single_status_pre: resp=%b data=%h want 1/%h", bus_resp_o, bus_rdata_bo, e);
        end
        checks++;
        if (ap_start_o !== 1'b0 || busy_o !== 1'b0 || irq_o !== 1'b1) begin
            errors++; $display("FAIL single_after: start=%b busy=%b irq=%b want 0/0/1", ap_start_o, busy_o, irq_o);
        end
        bus_read(32'h0C, 32'h5, "single_ret");
    endtask

    task automatic test_timeout();
        int starts;
        int rsts;
        bus_write(32'h10, 32'd20);
        ap_idle_i = 1'b0;
        bus_write(32'h00, 32'h1);
        starts = 0; rsts = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (ap_start_o === 1'b1) starts++;
            if (accel_rst_o === 1'b1) rsts++;
            @(posedge clk_i); #1;
        end
        ap_idle_i = 1'b1;
        checks++;
        if (starts != 20) begin
            errors++; $display("FAIL timeout_len: got %0d start cycles want 20", starts);
        end
        checks++;
        if (rsts != 4) begin
            errors++; $display("FAIL timeout_rst_len: got %0d rst cycles want 4", rsts);
        end
        checks++;
        if (irq_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL timeout_irq: irq=%b busy=%b want 1/0", irq_o, busy_o);
        end
        bus_read(32'h04, 32'hC, "timeout_status");
        bus_read(32'h0C, 32'h5, "timeout_ret");
        bus_write(32'h10, 32'd0);
    endtask

    task automatic test_abort_busy();
        ap_idle_i = 1'b0;
        bus_write(32'h00, 32'h1);
        ap_ready_i = 1'b1;
        @(posedge clk_i); #1;
        ap_ready_i = 1'b0;
        bus_write(32'h00, 32'h1);
        @(negedge clk_i);
        checks++;
        if (ap_start_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL restart_ignored: start=%b busy=%b want 0/1", ap_start_o, busy_o);
        end
        bus_write(32'h08, 32'h77);
        bus_read(32'h08, 32'h10, "arg_busy");
        @(posedge clk_i); #1;
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = BASE; bus_be_bi = 4'h1; bus_wdata_bi = 32'h2;
        ap_done_i = 1'b1; ap_return_bi = 32'h1234;
        @(posedge clk_i); #1;
        bus_req_i = 1'b0; bus_we_i = 1'b0; ap_done_i = 1'b0; ap_return_bi = 32'd0;
        @(negedge clk_i);
        checks++;
        if (accel_rst_o !== 1'b1 || irq_o !== 1'b0) begin
            errors++; $display("FAIL abort_reset: rst=%b irq=%b want 1/0", accel_rst_o, irq_o);
        end
        wait_idle("abort");
        ap_idle_i = 1'b1;
        bus_read(32'h04, 32'h8, "abort_status");
        bus_read(32'h0C, 32'h5, "abort_ret");
    endtask

    task automatic test_bus_edges();
        bus_read(32'h18, 32'h0, "reserved_18");
        bus_read(32'h00, 32'h0, "ctrl_read");
        @(posedge clk_i); #1;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = BASE + 32'h40;
        @(negedge clk_i);
        checks++;
        if (bus_ack_o !== 1'b0) begin
            errors++; $display("FAIL oor_ack: got %b want 0", bus_ack_o);
        end
        @(posedge clk_i); #1;
        bus_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (bus_resp_o !== 1'b0) begin
            errors++; $display("FAIL oor_resp: got %b want 0", bus_resp_o);
        end
    endtask

    task automatic test_midrun_reset();
        bus_write(32'h10, 32'd99);
        bus_write(32'h00, 32'h1);
        #2;
        arst_n_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ap_start_o !== 1'b0 || accel_rst_o !== 1'b0 || arg_bo !== 32'd0) begin
            errors++; $display("FAIL midrun_reset: busy=%b start=%b rst=%b arg=%h want 0",
                busy_o, ap_start_o, accel_rst_o, arg_bo);
        end
        @(posedge clk_i); #1;
        arst_n_i = 1'b1;
        bus_read(32'h10, 32'd0, "midrun_timeout");
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_single_cycle();
        test_timeout();
        test_abort_busy();
        test_bus_edges();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
